// File: rtl/clock_crossing_pkg.sv
// Shared types and constants for the clock-crossing output path.
// Holds the skid-buffer state enum, default widths and an occupancy helper.
package clock_crossing_pkg;

    localparam int DEFAULT_DWIDTH = 32;
    localparam int COUNT_WIDTH    = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // The state encoding doubles as the held-beat count.
    function automatic logic [1:0] state_occupancy(input skid_state_t state);
        case (state)
            HALF:    return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/axis_beat_counter.sv
// Free-running wrap-around event counter with enable and synchronous clear.
// A clear that coincides with an enabled event leaves the count at 1.
module axis_beat_counter
    import clock_crossing_pkg::*;
#(
    parameter int WIDTH = COUNT_WIDTH
) (
    input  logic             srff_clock,
    input  logic             srff_aresetn,
    input  logic             enable,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge srff_clock or negedge srff_aresetn) begin
        if (!srff_aresetn) begin
            count <= '0;
        end else if (clear) begin
            count <= enable ? WIDTH'(1) : '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/axis_output_stage.sv
// Two-entry registered AXI-stream skid buffer feeding the consumer side.
// Define AXIS_OUTPUT_STAGE_STATS_EN to add beat/packet counters and stats_clr.
module axis_output_stage
    import clock_crossing_pkg::*;
#(
    parameter int DWIDTH    = DEFAULT_DWIDTH,
    parameter int KEEPWIDTH = DWIDTH / 8
) (
    input  logic                   srff_clock,
    input  logic                   srff_aresetn,
    input  logic [DWIDTH-1:0]      s_tdata,
    input  logic [KEEPWIDTH-1:0]   s_tkeep,
    input  logic                   s_tlast,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    output logic [DWIDTH-1:0]      m_tdata,
    output logic [KEEPWIDTH-1:0]   m_tkeep,
    output logic                   m_tlast,
    output logic                   m_tvalid,
    input  logic                   m_tready,
`ifdef AXIS_OUTPUT_STAGE_STATS_EN
    input  logic                   stats_clr,
    output logic [COUNT_WIDTH-1:0] beat_count,
    output logic [COUNT_WIDTH-1:0] pkt_count,
`endif
    output logic [1:0]             occupancy
);

    skid_state_t state, next_state;

    logic in_hs;
    logic out_hs;
    logic load_out_from_in;
    logic load_out_from_skid;
    logic load_skid;

    logic [DWIDTH-1:0]    skid_data;
    logic [KEEPWIDTH-1:0] skid_keep;
    logic                 skid_last;

    assign in_hs     = s_tvalid && s_tready;
    assign out_hs    = m_tvalid && m_tready;
    assign m_tvalid  = (state != EMPTY);
    assign occupancy = state_occupancy(state);

    always_comb begin
        next_state         = state;
        load_out_from_in   = 1'b0;
        load_out_from_skid = 1'b0;
        load_skid          = 1'b0;
        case (state)
            EMPTY: begin
                if (in_hs) begin
                    next_state       = HALF;
                    load_out_from_in = 1'b1;
                end
            end
            HALF: begin
                if (in_hs && out_hs) begin
                    load_out_from_in = 1'b1;
                end else if (in_hs) begin
                    next_state = FULL;
                    load_skid  = 1'b1;
                end else if (out_hs) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
                // s_tready is low here, so only the output side can move.
                if (out_hs) begin
                    next_state         = HALF;
                    load_out_from_skid = 1'b1;
                end
            end
            default: begin
                next_state = EMPTY;
            end
        endcase
    end

    // s_tready is a pure register so m_tready never reaches it combinationally.
    always_ff @(posedge srff_clock or negedge srff_aresetn) begin
        if (!srff_aresetn) begin
            state    <= EMPTY;
            s_tready <= 1'b0;
        end else begin
            state    <= next_state;
            s_tready <= (next_state != FULL);
        end
    end

    always_ff @(posedge srff_clock or negedge srff_aresetn) begin
        if (!srff_aresetn) begin
            m_tdata   <= '0;
            m_tkeep   <= '0;
            m_tlast   <= 1'b0;
            skid_data <= '0;
            skid_keep <= '0;
            skid_last <= 1'b0;
        end else begin
            if (load_out_from_in) begin
                m_tdata <= s_tdata;
                m_tkeep <= s_tkeep;
                m_tlast <= s_tlast;
            end else if (load_out_from_skid) begin
                m_tdata <= skid_data;
                m_tkeep <= skid_keep;
                m_tlast <= skid_last;
            end
            if (load_skid) begin
                skid_data <= s_tdata;
                skid_keep <= s_tkeep;
                skid_last <= s_tlast;
            end
        end
    end

`ifdef AXIS_OUTPUT_STAGE_STATS_EN
    axis_beat_counter #(
        .WIDTH(COUNT_WIDTH)
    ) u_beat_counter (
        .srff_clock  (srff_clock),
        .srff_aresetn(srff_aresetn),
        .enable      (out_hs),
        .clear       (stats_clr),
        .count       (beat_count)
    );

    axis_beat_counter #(
        .WIDTH(COUNT_WIDTH)
    ) u_pkt_counter (
        .srff_clock  (srff_clock),
        .srff_aresetn(srff_aresetn),
        .enable      (out_hs && m_tlast),
        .clear       (stats_clr),
        .count       (pkt_count)
    );
`endif

endmodule

// File: tb/tb_axis_output_stage.sv
// Self-checking bench for axis_output_stage: queue-based reference model plus directed checks.
// Stats checks are compiled in when AXIS_OUTPUT_STAGE_STATS_EN is defined.
`timescale 1ns/1ps
module tb_axis_output_stage;

    typedef struct packed {
        logic        last;
        logic [3:0]  keep;
        logic [31:0] data;
    } beat_t;

    logic        srff_clock   = 1'b0;
    logic        srff_aresetn = 1'b1;
    logic [31:0] s_tdata      = '0;
    logic [3:0]  s_tkeep      = '0;
    logic        s_tlast      = 1'b0;
    logic        s_tvalid     = 1'b0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready     = 1'b0;
    logic [1:0]  occupancy;
`ifdef AXIS_OUTPUT_STAGE_STATS_EN
    logic        stats_clr    = 1'b0;
    logic [31:0] beat_count;
    logic [31:0] pkt_count;
    logic [31:0] exp_beats    = '0;
    logic [31:0] exp_pkts     = '0;
`endif

    int    total    = 0;
    int    bad      = 0;
    int    accepted = 0;
    beat_t exp_q[$];
    logic  model_ready = 1'b0;
    logic  m_in_hs;
    logic  m_out_hs;

    axis_output_stage dut (
        .srff_clock  (srff_clock),
        .srff_aresetn(srff_aresetn),
        .s_tdata     (s_tdata),
        .s_tkeep     (s_tkeep),
        .s_tlast     (s_tlast),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .m_tdata     (m_tdata),
        .m_tkeep     (m_tkeep),
        .m_tlast     (m_tlast),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
`ifdef AXIS_OUTPUT_STAGE_STATS_EN
        .stats_clr   (stats_clr),
        .beat_count  (beat_count),
        .pkt_count   (pkt_count),
`endif
        .occupancy   (occupancy)
    );

    always #5 srff_clock = ~srff_clock;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs at posedge+1 and return just after the next edge.
    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [3:0] k,
                                 input logic l, input logic r);
        s_tvalid = v;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        m_tready = r;
        @(posedge srff_clock);
        #1;
    endtask

    // Reference model: a FIFO of accepted-but-not-emitted beats, at most two deep.
    always @(negedge srff_clock) begin
        if (!srff_aresetn) begin
            exp_q.delete();
            model_ready = 1'b0;
            checkOutput("rst_m_tvalid", m_tvalid, 0);
            checkOutput("rst_s_tready", s_tready, 0);
            checkOutput("rst_occupancy", occupancy, 0);
            checkOutput("rst_m_tdata", m_tdata, 0);
`ifdef AXIS_OUTPUT_STAGE_STATS_EN
            exp_beats = '0;
            exp_pkts  = '0;
            checkOutput("rst_beat_count", beat_count, 0);
            checkOutput("rst_pkt_count", pkt_count, 0);
`endif
        end else begin
            checkOutput("m_tvalid", m_tvalid, exp_q.size() > 0);
            checkOutput("s_tready", s_tready, model_ready);
            checkOutput("occupancy", occupancy, exp_q.size());
            if (exp_q.size() > 0) begin
                checkOutput("m_tdata", m_tdata, exp_q[0].data);
                checkOutput("m_tkeep", m_tkeep, exp_q[0].keep);
                checkOutput("m_tlast", m_tlast, exp_q[0].last);
            end
            m_in_hs  = s_tvalid && model_ready;
            m_out_hs = (exp_q.size() > 0) && m_tready;
`ifdef AXIS_OUTPUT_STAGE_STATS_EN
            checkOutput("beat_count", beat_count, exp_beats);
            checkOutput("pkt_count", pkt_count, exp_pkts);
            if (stats_clr) begin
                exp_beats = m_out_hs ? 32'd1 : 32'd0;
                exp_pkts  = (m_out_hs && exp_q[0].last) ? 32'd1 : 32'd0;
            end else if (m_out_hs) begin
                exp_beats = exp_beats + 32'd1;
                if (exp_q[0].last) exp_pkts = exp_pkts + 32'd1;
            end
`endif
            if (m_out_hs) void'(exp_q.pop_front());
            if (m_in_hs) begin
                exp_q.push_back({s_tlast, s_tkeep, s_tdata});
                accepted++;
            end
            model_ready = (exp_q.size() < 2);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        #1 srff_aresetn = 1'b0;
        repeat (3) @(posedge srff_clock);
        #1 srff_aresetn = 1'b1;

        // Release: ready must come up on the first edge, not before.
        @(negedge srff_clock);
        checkOutput("pre_edge_s_tready", s_tready, 0);
        @(posedge srff_clock);
        #1;
        checkOutput("post_edge_s_tready", s_tready, 1);
        checkOutput("post_edge_m_tvalid", m_tvalid, 0);
        checkOutput("post_edge_occupancy", occupancy, 0);

        // Streaming at full rate.
        applyStimulus(1, 32'h11, 4'hF, 0, 1);
        checkOutput("stream_0x11", m_tdata, 32'h11);
        checkOutput("stream_occ1", occupancy, 1);
        applyStimulus(1, 32'h22, 4'hF, 0, 1);
        checkOutput("stream_0x22", m_tdata, 32'h22);
        applyStimulus(1, 32'h33, 4'hF, 1, 1);
        checkOutput("stream_0x33", m_tdata, 32'h33);
        checkOutput("stream_occ1_end", occupancy, 1);
        applyStimulus(0, 32'h0, 4'h0, 0, 1);
        checkOutput("stream_drained_valid", m_tvalid, 0);

        // Back-pressure fills the skid, then drains in order.
        applyStimulus(1, 32'hA1, 4'h3, 0, 0);
        checkOutput("bp_occ1", occupancy, 1);
        checkOutput("bp_ready_half", s_tready, 1);
        applyStimulus(1, 32'hA2, 4'hF, 1, 0);
        checkOutput("bp_occ2", occupancy, 2);
        checkOutput("bp_ready_full", s_tready, 0);
        checkOutput("bp_hold_A1", m_tdata, 32'hA1);
        applyStimulus(0, 32'h0, 4'h0, 0, 0);
        checkOutput("bp_still_A1", m_tdata, 32'hA1);
        applyStimulus(0, 32'h0, 4'h0, 0, 1);
        checkOutput("bp_then_A2", m_tdata, 32'hA2);
        checkOutput("bp_occ_after_pop", occupancy, 1);
        applyStimulus(0, 32'h0, 4'h0, 0, 1);
        checkOutput("bp_occ0", occupancy, 0);

        // Reset while full discards both beats.
        applyStimulus(1, 32'hB1, 4'hF, 0, 0);
        applyStimulus(1, 32'hB2, 4'hF, 0, 0);
        checkOutput("rstfull_occ2", occupancy, 2);
        srff_aresetn = 1'b0;
        #1;
        checkOutput("rstfull_m_tvalid", m_tvalid, 0);
        checkOutput("rstfull_occupancy", occupancy, 0);
        @(posedge srff_clock);
        #1;
        s_tvalid     = 1'b0;
        m_tready     = 1'b1;
        srff_aresetn = 1'b1;
        repeat (3) begin
            applyStimulus(0, 32'h0, 4'h0, 0, 1);
            checkOutput("rstfull_no_stale", m_tvalid, 0);
        end

        // Random traffic: the model process checks every cycle.
        base = accepted;
        for (int c = 0; c < 40000 && (accepted - base) < 10000; c++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0);
        end
        checkOutput("random_accept_count", accepted - base, 10000);
        repeat (4) applyStimulus(0, 32'h0, 4'h0, 0, 1);
        checkOutput("drain_occupancy", occupancy, 0);

`ifdef AXIS_OUTPUT_STAGE_STATS_EN
        stats_clr = 1'b1;
        applyStimulus(0, 32'h0, 4'h0, 0, 1);
        stats_clr = 1'b0;
        checkOutput("stats_cleared", beat_count, 0);
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 5; b++) begin
                applyStimulus(1, 32'(p * 16 + b), 4'hF, b == 4, 1);
            end
        end
        applyStimulus(0, 32'h0, 4'h0, 0, 1);
        checkOutput("stats_beats_15", beat_count, 15);
        checkOutput("stats_pkts_3", pkt_count, 3);
        applyStimulus(1, 32'hC0, 4'hF, 1, 1);
        stats_clr = 1'b1;
        applyStimulus(0, 32'h0, 4'h0, 0, 1);
        stats_clr = 1'b0;
        checkOutput("stats_clr_count_wins_beat", beat_count, 1);
        checkOutput("stats_clr_count_wins_pkt", pkt_count, 1);
`endif

        @(negedge srff_clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
